// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared I2S constants, types and helpers for the RX/TX path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // Bits per lrclk half-frame as produced by i2s_clock_gen
  localparam int I2S_HALF_FRAME_BITS = 32;
  // Default captured word width and MSB position (standard I2S one-bit delay)
  localparam int I2S_DATA_WIDTH      = 24;
  localparam int I2S_BIT_OFFSET      = 1;
  // Width of a counter that indexes every bit of a half-frame
  localparam int I2S_CNT_W           = $clog2(I2S_HALF_FRAME_BITS);

  typedef logic signed [I2S_DATA_WIDTH-1:0] sample_t;
  typedef logic [I2S_CNT_W-1:0]             bit_cnt_t;

  // Next half-frame bit index; holds at the last index of the half-frame
  function automatic bit_cnt_t bit_cnt_next(input bit_cnt_t cnt);
    return (cnt == bit_cnt_t'(I2S_HALF_FRAME_BITS - 1)) ? cnt : cnt + bit_cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_stream_if
//  Description : valid/ready sample stream between the I2S receiver and DSP.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_rx_stream_if #(
  parameter int DATA_WIDTH = 24
);
  logic signed [DATA_WIDTH-1:0] m_data;
  logic                         m_valid;
  logic                         m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with occupancy.
//                A push into a full FIFO only lands when a pop happens in
//                the same cycle; otherwise it is silently refused.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]         r_wr_ptr;
  logic [c_AW:0]         r_rd_ptr;
  logic [c_AW:0]         r_level;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Extra pointer MSB separates the full and empty cases when low bits match
  assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_pop  = i_pop & ~w_empty;
  // When full, the slot being written is the one being popped this cycle
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage write; cleared on reset so the head word reads 0 afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping, updated together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/i2s_rx_stream.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_stream
//  Description : Oversampling I2S receiver. Captures one channel's word per
//                frame and buffers it for a valid/ready consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_stream
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH      = I2S_DATA_WIDTH,
  parameter int CAPTURE_CHANNEL = 0,
  parameter int BIT_OFFSET      = I2S_BIT_OFFSET,
  parameter int FIFO_DEPTH      = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bclk,
  input  logic                        lrclk,
  input  logic                        sdata,
  i2s_rx_stream_if.master             m_stream,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        short_frame,
  input  logic                        flags_clear
);

  localparam bit_cnt_t c_BIT_FIRST = bit_cnt_t'(BIT_OFFSET);
  localparam bit_cnt_t c_BIT_LAST  = bit_cnt_t'(BIT_OFFSET + DATA_WIDTH - 1);
  localparam logic     c_CAP_LVL   = (CAPTURE_CHANNEL != 0);

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   r_bclk_d;
  logic                   r_lrclk_prev;
  logic                   r_lr_valid;
  logic                   r_aligned;
  bit_cnt_t               r_bit_cnt;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic                   r_overflow;
  logic                   r_short_frame;

  logic                   w_bclk_s;
  logic                   w_lrclk_s;
  logic                   w_sdata_s;
  logic                   w_rise;
  logic                   w_lr_change;
  logic                   w_lr_edge;
  bit_cnt_t               w_bit_idx;
  logic                   w_in_cap;
  logic                   w_in_window;
  logic                   w_capture;
  logic [DATA_WIDTH-1:0]  w_shift_base;
  logic [DATA_WIDTH-1:0]  w_word;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_short_set;
  logic                   w_ovf_set;
  logic [DATA_WIDTH-1:0]  w_fifo_data;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  // Input synchronisers plus the previous synchronised bclk for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_sync  <= '0;
      r_lrclk_sync <= '0;
      r_sdata_sync <= '0;
      r_bclk_d     <= 1'b0;
    end else begin
      r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], bclk};
      r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], lrclk};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata};
      r_bclk_d     <= w_bclk_s;
    end
  end

  assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrclk_s   = r_lrclk_sync[SYNC_STAGES-1];
  assign w_sdata_s   = r_sdata_sync[SYNC_STAGES-1];
  assign w_rise      = w_bclk_s & ~r_bclk_d;

  // lrclk_prev is only meaningful after the first bit event since reset, so
  // a true half-frame boundary needs that history; until one is seen the
  // receiver is mid-frame and must not capture or flag anything.
  assign w_lr_change = w_lrclk_s ^ r_lrclk_prev;
  assign w_lr_edge   = w_lr_change & r_lr_valid;

  // Index of the bit being sampled on this rise within its half-frame
  assign w_bit_idx   = w_lr_change ? '0 : bit_cnt_next(r_bit_cnt);
  assign w_in_cap    = (w_lrclk_s == c_CAP_LVL) & (r_aligned | w_lr_edge);
  assign w_in_window = (w_bit_idx >= c_BIT_FIRST) && (w_bit_idx <= c_BIT_LAST);
  assign w_capture   = w_rise & w_in_cap & w_in_window;

  // A boundary rise starts from an empty shift register
  assign w_shift_base = w_lr_change ? '0 : r_shift;
  assign w_word       = {w_shift_base[DATA_WIDTH-2:0], w_sdata_s};
  assign w_push       = w_capture & (w_bit_idx == c_BIT_LAST);

  // Capture half-frame ended after its MSB but before its LSB arrived
  assign w_short_set  = w_rise & w_lr_edge & r_aligned &
                        (r_lrclk_prev == c_CAP_LVL) &
                        (r_bit_cnt >= c_BIT_FIRST) && (r_bit_cnt < c_BIT_LAST);

  assign w_pop        = ~w_fifo_empty & m_stream.m_ready;
  assign w_ovf_set    = w_push & w_fifo_full & ~w_pop;

  // Half-frame bit counter and MSB-first shift register, advanced on bit events
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lrclk_prev <= 1'b0;
      r_lr_valid   <= 1'b0;
      r_aligned    <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
    end else if (w_rise) begin
      r_lrclk_prev <= w_lrclk_s;
      r_lr_valid   <= 1'b1;
      r_bit_cnt    <= w_bit_idx;
      if (w_lr_edge) r_aligned <= 1'b1;
      if (w_capture) begin
        r_shift <= w_word;
      end else if (w_lr_change) begin
        r_shift <= '0;
      end
    end
  end

  // Sticky status flags; a set event in the clear cycle keeps the flag high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow    <= 1'b0;
      r_short_frame <= 1'b0;
    end else begin
      r_overflow    <= w_ovf_set   | (r_overflow    & ~flags_clear);
      r_short_frame <= w_short_set | (r_short_frame & ~flags_clear);
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (level)
  );

  assign m_stream.m_data  = w_fifo_data;
  assign m_stream.m_valid = ~w_fifo_empty;
  assign overflow         = r_overflow;
  assign short_frame      = r_short_frame;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx_stream
//  Description : Directed bench for i2s_rx_stream. Each bclk phase is 4 clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_stream;
  import i2s_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       bclk;
  logic       lrclk;
  logic       sdata;
  logic       flags_clear;
  logic [2:0] level;
  logic       overflow;
  logic       short_frame;

  int n_cmp = 0;
  int n_bad = 0;

  sample_t q_out [$];

  i2s_rx_stream_if #(.DATA_WIDTH(24)) s_if ();

  i2s_rx_stream #(
    .DATA_WIDTH      (24),
    .CAPTURE_CHANNEL (0),
    .BIT_OFFSET      (1),
    .FIFO_DEPTH      (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .m_stream    (s_if),
    .level       (level),
    .overflow    (overflow),
    .short_frame (short_frame),
    .flags_clear (flags_clear)
  );

  always #5 clk = ~clk;

  // Record every word the consumer accepts (inputs are stable since negedge)
  always @(posedge clk) begin
    if (s_if.m_valid && s_if.m_ready) q_out.push_back(s_if.m_data);
  end

  // Drive half-frame bits first..last; kind selects an action at bit pbit:
  // 1 = latency/pulse check, 2 = m_ready pulse in the push cycle,
  // 3 = flags_clear pulse in the bit-event cycle
  task automatic send_half(input logic lr, input sample_t word, input int first,
                           input int last, input logic tog, input int kind,
                           input int pbit, input sample_t expw);
    for (int i = first; i <= last; i++) begin
      bclk  = 1'b0;
      lrclk = lr;
      if (i >= 1 && i <= 24) sdata = word[24-i];
      else                   sdata = tog ? i[0] : 1'b1;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (i == pbit) begin
        if (kind == 1) begin
          n_cmp++;
          if (s_if.m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: m_valid=%b required 0", s_if.m_valid);
          end
        end
        if (kind == 2) s_if.m_ready = 1'b1;
        if (kind == 3) flags_clear = 1'b1;
      end
      @(negedge clk);
      if (i == pbit) begin
        if (kind == 1) begin
          n_cmp++;
          if (s_if.m_valid !== 1'b1 || s_if.m_data !== expw) begin
            n_bad++;
            $display("FAIL latency_word: m_valid=%b m_data=%h required 1/%h",
                     s_if.m_valid, s_if.m_data, expw);
          end
        end
        if (kind == 2) s_if.m_ready = 1'b0;
        if (kind == 3) flags_clear = 1'b0;
      end
      @(negedge clk);
      if (i == pbit && kind == 1) begin
        n_cmp++;
        if (s_if.m_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL valid_pulse: m_valid=%b required 0", s_if.m_valid);
        end
      end
    end
  endtask

  task automatic send_frame(input sample_t l, input sample_t r, input logic tog, input int kind);
    send_half(1'b0, l, 0, 31, tog, kind, 24, l);
    send_half(1'b1, r, 0, 31, tog, 0, -1, '0);
  endtask

  task automatic test_reset;
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    flags_clear = 1'b0; s_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (s_if.m_valid !== 1'b0 || s_if.m_data !== 24'h0 || level !== 3'd0 ||
        overflow !== 1'b0 || short_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b data=%h level=%0d ovf=%b short=%b required all 0",
               s_if.m_valid, s_if.m_data, level, overflow, short_frame);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    s_if.m_ready = 1'b1;
    // right half first to give the receiver a real boundary
    send_half(1'b1, 24'h0F0F0F, 0, 31, 1'b0, 0, -1, '0);
    q_out.delete();
    send_frame(24'hA5C3F1, 24'h123456, 1'b0, 1);
    send_frame(24'hA5C3F1, 24'h123456, 1'b0, 1);
    n_cmp++;
    if (q_out.size() !== 2) begin
      n_bad++;
      $display("FAIL basic_count: got %0d words required 2", q_out.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (q_out[i] !== 24'hA5C3F1) begin
        n_bad++;
        $display("FAIL basic_word%0d: got %h required a5c3f1", i, q_out[i]);
      end
    end
  endtask

  task automatic test_negative;
    q_out.delete();
    send_frame(24'h800001, 24'hFFFFFF, 1'b1, 1);
    n_cmp++;
    if (q_out.size() !== 1 || q_out[0] !== 24'h800001) begin
      n_bad++;
      $display("FAIL negative_word: n=%0d got %h required 1/800001", q_out.size(), q_out[0]);
    end
  endtask

  task automatic test_overflow;
    sample_t exp_q [4] = '{24'h1, 24'h2, 24'h3, 24'h4};
    s_if.m_ready = 1'b0;
    q_out.delete();
    for (int f = 1; f <= 5; f++) send_frame(sample_t'(f), 24'h777777, 1'b0, 0);
    n_cmp++;
    if (level !== 3'd4 || overflow !== 1'b1 || s_if.m_data !== 24'h1) begin
      n_bad++;
      $display("FAIL overflow_state: level=%0d ovf=%b head=%h required 4/1/000001",
               level, overflow, s_if.m_data);
    end
    s_if.m_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (q_out.size() !== 4 || level !== 3'd0) begin
      n_bad++;
      $display("FAIL overflow_drain: n=%0d level=%0d required 4/0", q_out.size(), level);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_out[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL overflow_order%0d: got %h required %h", i, q_out[i], exp_q[i]);
      end
    end
    flags_clear = 1'b1;
    @(negedge clk);
    flags_clear = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_clear: ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_back_to_back;
    sample_t exp_q [5] = '{24'h7, 24'h8, 24'h9, 24'hA, 24'hB};
    s_if.m_ready = 1'b0;
    q_out.delete();
    for (int f = 7; f <= 10; f++) send_frame(sample_t'(f), 24'h0, 1'b0, 0);
    send_frame(24'hB, 24'h0, 1'b0, 2);
    n_cmp++;
    if (level !== 3'd4 || overflow !== 1'b0 || s_if.m_data !== 24'h8) begin
      n_bad++;
      $display("FAIL full_pop_state: level=%0d ovf=%b head=%h required 4/0/000008",
               level, overflow, s_if.m_data);
    end
    s_if.m_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (q_out.size() !== 5) begin
      n_bad++;
      $display("FAIL full_pop_count: got %0d required 5", q_out.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (q_out[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL full_pop_order%0d: got %h required %h", i, q_out[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_short_frame;
    s_if.m_ready = 1'b1;
    q_out.delete();
    // left half cut after 10 data bits
    send_half(1'b0, 24'hABCDEF, 0, 10, 1'b0, 0, -1, '0);
    send_half(1'b1, 24'h0, 0, 31, 1'b0, 0, -1, '0);
    n_cmp++;
    if (short_frame !== 1'b1 || q_out.size() !== 0 || level !== 3'd0) begin
      n_bad++;
      $display("FAIL short_set: short=%b n=%0d level=%0d required 1/0/0",
               short_frame, q_out.size(), level);
    end
    flags_clear = 1'b1;
    @(negedge clk);
    flags_clear = 1'b0;
    n_cmp++;
    if (short_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL short_clear: short=%b required 0", short_frame);
    end
    send_frame(24'h5A5A5A, 24'h0, 1'b0, 1);
    n_cmp++;
    if (q_out.size() !== 1 || q_out[0] !== 24'h5A5A5A) begin
      n_bad++;
      $display("FAIL short_recover: n=%0d got %h required 1/5a5a5a", q_out.size(), q_out[0]);
    end
    send_half(1'b0, 24'h123123, 0, 10, 1'b0, 0, -1, '0);
    send_half(1'b1, 24'h0, 0, 31, 1'b0, 3, 0, '0);
    n_cmp++;
    if (short_frame !== 1'b1 || q_out.size() !== 1) begin
      n_bad++;
      $display("FAIL short_clear_race: short=%b n=%0d required 1/1", short_frame, q_out.size());
    end
  endtask

  task automatic test_reset_mid;
    s_if.m_ready = 1'b0;
    send_frame(24'h111111, 24'h0, 1'b0, 0);
    send_frame(24'h222222, 24'h0, 1'b0, 0);
    n_cmp++;
    if (level !== 3'd2) begin
      n_bad++;
      $display("FAIL reset_mid_queued: level=%0d required 2", level);
    end
    send_half(1'b0, 24'h333333, 0, 12, 1'b0, 0, -1, '0);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_if.m_valid !== 1'b0 || s_if.m_data !== 24'h0 || level !== 3'd0 ||
        overflow !== 1'b0 || short_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_state: valid=%b data=%h level=%0d ovf=%b short=%b required all 0",
               s_if.m_valid, s_if.m_data, level, overflow, short_frame);
    end
    reset = 1'b0;
    s_if.m_ready = 1'b1;
    q_out.delete();
    send_half(1'b0, 24'h333333, 13, 31, 1'b0, 0, -1, '0);
    send_half(1'b1, 24'h0, 0, 31, 1'b0, 0, -1, '0);
    send_frame(24'h444444, 24'h0, 1'b0, 1);
    n_cmp++;
    if (q_out.size() !== 1 || q_out[0] !== 24'h444444 || short_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_next: n=%0d first=%h short=%b required 1/444444/0",
               q_out.size(), q_out[0], short_frame);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_short_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_rx_stream.md
Name: i2s_rx_stream

Overview:
- Clk-domain I2S receiver.
- Oversamples bclk/lrclk/sdata from the bus driven by i2s_clock_gen, captures one channel's word and buffers it in a small FIFO.
- Presents words to the downstream DSP/processing chain on a valid/ready stream.
- Sits between the I2S pins (mic ADC) and the sample pipeline that ultimately feeds the I2S transmitter.

Parameters:
- DATA_WIDTH, 24, captured word width (≤ 31).
- CAPTURE_CHANNEL, 0, lrclk level of the captured half-frame.
- BIT_OFFSET, 1, bit index of the MSB within the half-frame (I2S delay).
- FIFO_DEPTH, 4, output buffer depth in words; power of 2, ≥ 2.
- SYNC_STAGES, 2, flip-flop synchroniser depth on each input; ≥ 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- bclk  in  1  I2S bit clock, asynchronous to clk.
- lrclk  in  1  I2S word select, asynchronous.
- sdata  in  1  I2S serial data, asynchronous.
- m_data  out  DATA_WIDTH  signed word at FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a completed word was dropped.
- short_frame  out  1  sticky: capture half-frame ended before the LSB.
- flags_clear  in  1  clears overflow and short_frame.

Behaviour:
- Reset state: all outputs 0 (m_valid=0, m_data=0, level=0, flags=0). FIFO emptied, bit_cnt=0, shift register=0, synchronisers and edge-detect registers=0. Reset mid-word discards the partial word.
- Synchronisation: bclk, lrclk and sdata each pass through SYNC_STAGES FFs. bclk_d holds the previous synchronised bclk.
- Bit event: rise = bclk_s & ~bclk_d. No other logic advances without rise.
- Clock requirement: clk ≥ 4× bclk frequency, with bclk high and low each ≥ 2 clk periods. With the default clock_gen dividers, each bclk phase is 10 clk.
- Half-frame counter, updated on rise:
  - if lrclk_s ≠ lrclk_prev: bit_cnt←0, shift←0;
  - else bit_cnt saturates at 31.
  - lrclk_prev is updated on rise only.
- Capture: on rise with lrclk_s==CAPTURE_CHANNEL and BIT_OFFSET ≤ bit_cnt ≤ BIT_LAST (BIT_LAST = BIT_OFFSET+DATA_WIDTH−1), shift ← {shift[DATA_WIDTH−2:0], sdata_s}. MSB first.
- Word completion: rise at bit_cnt==BIT_LAST in the capture channel pushes {shift[DATA_WIDTH−2:0], sdata_s} into the FIFO in that same clk cycle. Exactly one push per frame.
- Short frame: an lrclk edge leaving the capture channel while BIT_OFFSET ≤ bit_cnt < BIT_LAST sets short_frame. No push occurs for that frame.
- Latency: the clk edge k at which sync stage 1 first samples the LSB's bclk rise. m_valid (if the FIFO was empty) is visible after edge k+SYNC_STAGES.
- FIFO:
  - First-word fall-through: m_data = mem[rd_ptr].
  - Pop when m_valid & m_ready.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full when the pointer MSBs differ and the low bits are equal.
- Push while full:
  - With a simultaneous pop, both occur and no data is lost.
  - Otherwise the new word is dropped, overflow←1, and the FIFO contents are untouched.
- level is registered and updates in the same cycle as the pointers: +1 push, −1 pop, 0 for both.
- m_ready while empty: ignored.
- m_data is not required to hold its value while m_valid=0.
- flags_clear: clears both flags. A same-cycle set event wins (flag stays 1).
- Data is not sign-processed; m_data is the raw two's-complement word.

Decomposition:
- Shared package i2s_pkg:
  - I2S_HALF_FRAME_BITS=32
  - default DATA_WIDTH=24
  - BIT_OFFSET=1
  - sample typedef (signed [DATA_WIDTH−1:0])
- Sub-module sync_fifo (DATA_WIDTH, DEPTH): push/pop/full/empty/level. Reusable by the TX side.
- Synchronisers are inline.

Test Plan:
- Left word 0xA5C3F1 in the capture channel, right word 0x123456, m_ready=1 → one m_valid pulse per frame with m_data=0xA5C3F1, latency as specified. 0x123456 is never emitted.
- Word 0x800001 (negative) → m_data=0x800001; bits 0..BIT_OFFSET−1 and bits after BIT_LAST are toggling 1s, which must not corrupt the word.
- m_ready=0 for 5 frames carrying 1,2,3,4,5 → level=4, overflow=1. Then m_ready=1 drains 1,2,3,4 in order; 5 is absent.
- FIFO full, m_ready=1 in the exact cycle of a push → no overflow, level stays 4, and order is preserved.
- lrclk toggled after 10 capture-channel bits → short_frame=1 and no push. A following full frame is captured correctly. flags_clear coincident with a new short frame leaves short_frame=1.
- reset asserted for 1 clk mid-word (bit 12) with 2 words queued → all outputs 0 next cycle. The first word after reset comes from the next complete frame only.
